// File: rtl/layer_output_serializer_pkg.sv
// Shared definitions for the layer output serializer: FSM state encoding.
package layer_output_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/layer_output_serializer_if.sv
// Parallel neuron-output capture bus and serial replay stream of the layer output serializer.
interface layer_output_serializer_if #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
);

  logic [NN-1:0]           i_valid;
  logic [NN*dataWidth-1:0] i_data;
  logic                    clr_err;
  logic                    x_valid;
  logic [dataWidth-1:0]    x_out;
  logic                    x_last;
  logic                    busy;
  logic                    err_overrun;
  logic                    err_partial;

  // Upstream layer plus downstream consumer side.
  modport master (
    output i_valid, i_data, clr_err,
    input  x_valid, x_out, x_last, busy, err_overrun, err_partial
  );

  // Serializer side.
  modport slave (
    input  i_valid, i_data, clr_err,
    output x_valid, x_out, x_last, busy, err_overrun, err_partial
  );

endinterface

// File: rtl/layer_output_serializer.sv
// Captures an NN-word parallel neuron output vector and replays it one word per clock,
// accepting a new vector in the last-word cycle so consecutive vectors stream without a bubble.
module layer_output_serializer
  import layer_output_serializer_pkg::*;
#(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  layer_output_serializer_if.slave   bus
);

  localparam int                IDX_W    = $clog2(NN);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NN - 1);

  state_e                  state, state_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic [NN*dataWidth-1:0] hold, hold_next;
  logic [dataWidth-1:0]    x_out_q, x_out_next;
  logic                    err_overrun_q, err_partial_q;
  logic                    capture, partial, at_last, overrun;
  int                      sel_base;

  assign capture = &bus.i_valid;
  assign partial = (|bus.i_valid) && !capture;
  assign at_last = (state == ST_SHIFT) && (idx == LAST_IDX);
  // A capture is only legal from IDLE or in the final-word cycle; anything else is dropped.
  assign overrun = capture && (state == ST_SHIFT) && !at_last;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    idx_next   = idx;
    hold_next  = hold;
    x_out_next = x_out_q;
    sel_base   = 0;
    case (state)
      ST_IDLE: begin
        if (capture) begin
          state_next = ST_SHIFT;
          idx_next   = '0;
          hold_next  = bus.i_data;
          x_out_next = bus.i_data[dataWidth-1:0];
        end
      end
      ST_SHIFT: begin
        if (at_last) begin
          if (capture) begin
            idx_next   = '0;
            hold_next  = bus.i_data;
            x_out_next = bus.i_data[dataWidth-1:0];
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          // x_out is registered, so preload the word that belongs to the next cycle's index.
          idx_next   = idx + 1'b1;
          sel_base   = int'(idx_next) * dataWidth;
          x_out_next = hold[sel_base +: dataWidth];
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the holding register is reset too, so x_out and any replay start from a known zero vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      hold          <= '0;
      x_out_q       <= '0;
      err_overrun_q <= 1'b0;
      err_partial_q <= 1'b0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      hold          <= hold_next;
      x_out_q       <= x_out_next;
      // A new error in the same cycle as clr_err keeps the flag set.
      err_overrun_q <= overrun || (err_overrun_q && !bus.clr_err);
      err_partial_q <= partial || (err_partial_q && !bus.clr_err);
    end
  end

  assign bus.x_valid     = (state == ST_SHIFT);
  assign bus.busy        = (state == ST_SHIFT);
  assign bus.x_last      = at_last;
  assign bus.x_out       = x_out_q;
  assign bus.err_overrun = err_overrun_q;
  assign bus.err_partial = err_partial_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed checks of the serializer at NN=4 plus a back-to-back scoreboard run at NN=10.
module tb_layer_output_serializer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  layer_output_serializer_if #(.NN(4),  .dataWidth(16)) bus4 ();
  layer_output_serializer_if #(.NN(10), .dataWidth(16)) bus10 ();

  layer_output_serializer #(.NN(4), .dataWidth(16)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  layer_output_serializer #(.NN(10), .dataWidth(16)) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus10)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge: inputs set here apply to that cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap4(input logic [63:0] v);
    bus4.i_valid = 4'hF;
    bus4.i_data  = v;
  endtask

  task automatic check_word4(input string tag, input logic [15:0] exp_word, input logic exp_last);
    check({tag, "_valid"}, 64'(bus4.x_valid), 64'd1);
    check({tag, "_busy"},  64'(bus4.busy),    64'd1);
    check({tag, "_data"},  64'(bus4.x_out),   64'(exp_word));
    check({tag, "_last"},  64'(bus4.x_last),  64'(exp_last));
  endtask

  localparam logic [63:0] VEC_A = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [63:0] VEC_B = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
  localparam logic [63:0] VEC_D = {16'h000D, 16'h000C, 16'h000B, 16'h000A};

  logic [159:0] v10;
  logic [15:0]  sb[$];
  logic [15:0]  exp_word;

  initial begin
    rst           = 1'b1;
    bus4.i_valid  = '0;
    bus4.i_data   = '0;
    bus4.clr_err  = 1'b0;
    bus10.i_valid = '0;
    bus10.i_data  = '0;
    bus10.clr_err = 1'b0;

    // Reset state
    #12;
    check("rst_valid",   64'(bus4.x_valid),     64'd0);
    check("rst_xout",    64'(bus4.x_out),       64'd0);
    check("rst_last",    64'(bus4.x_last),      64'd0);
    check("rst_busy",    64'(bus4.busy),        64'd0);
    check("rst_overrun", 64'(bus4.err_overrun), 64'd0);
    check("rst_partial", 64'(bus4.err_partial), 64'd0);
    check("rst_valid10", 64'(bus10.x_valid),    64'd0);
    rst = 1'b0;
    step();

    // 1: single vector, latency and x_last placement
    check("t1_idle", 64'(bus4.x_valid), 64'd0);
    cap4(VEC_A);
    step();
    bus4.i_valid = '0;
    for (int k = 0; k < 4; k++) begin
      check_word4($sformatf("t1_w%0d", k), 16'(k + 1), k == 3);
      step();
    end
    check("t1_busy_fall", 64'(bus4.busy),        64'd0);
    check("t1_valid_off", 64'(bus4.x_valid),     64'd0);
    check("t1_hold_xout", 64'(bus4.x_out),       64'd4);
    check("t1_overrun",   64'(bus4.err_overrun), 64'd0);

    // 2: second capture exactly in the x_last cycle -> contiguous stream
    cap4(VEC_A);
    step();
    bus4.i_valid = '0;
    for (int k = 0; k < 8; k++) begin
      check_word4($sformatf("t2_w%0d", k), 16'(k + 1), (k == 3) || (k == 7));
      if (k == 3) cap4(VEC_B);
      else        bus4.i_valid = '0;
      step();
    end
    check("t2_busy_fall", 64'(bus4.busy),        64'd0);
    check("t2_overrun",   64'(bus4.err_overrun), 64'd0);

    // 3: capture mid-stream is dropped and flagged; clr_err clears it
    cap4(VEC_A);
    step();
    bus4.i_valid = '0;
    for (int k = 0; k < 4; k++) begin
      check_word4($sformatf("t3_w%0d", k), 16'(k + 1), k == 3);
      if (k == 1) cap4(VEC_B);
      else        bus4.i_valid = '0;
      step();
    end
    check("t3_busy_fall", 64'(bus4.busy),        64'd0);
    check("t3_dropped",   64'(bus4.x_valid),     64'd0);
    check("t3_overrun",   64'(bus4.err_overrun), 64'd1);
    bus4.clr_err = 1'b1;
    step();
    bus4.clr_err = 1'b0;
    check("t3_overrun_clr", 64'(bus4.err_overrun), 64'd0);

    // 4: partial valid -> flag only; a same-cycle new error beats clr_err
    bus4.i_valid = 4'b0101;
    bus4.i_data  = VEC_B;
    step();
    bus4.i_valid = '0;
    check("t4_valid",   64'(bus4.x_valid),     64'd0);
    check("t4_busy",    64'(bus4.busy),        64'd0);
    check("t4_partial", 64'(bus4.err_partial), 64'd1);
    check("t4_overrun", 64'(bus4.err_overrun), 64'd0);
    bus4.i_valid = 4'b0101;
    bus4.clr_err = 1'b1;
    step();
    bus4.i_valid = '0;
    check("t4_err_wins", 64'(bus4.err_partial), 64'd1);
    check("t4_no_emit",  64'(bus4.x_valid),     64'd0);
    step();
    bus4.clr_err = 1'b0;
    check("t4_partial_clr", 64'(bus4.err_partial), 64'd0);

    // 5: async reset mid-stream, then a fresh vector starts from word 0
    cap4(VEC_A);
    step();
    bus4.i_valid = '0;
    check_word4("t5_w0", 16'd1, 1'b0);
    step();
    check_word4("t5_w1", 16'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", 64'(bus4.x_valid), 64'd0);
    check("t5_rst_xout",  64'(bus4.x_out),   64'd0);
    check("t5_rst_last",  64'(bus4.x_last),  64'd0);
    check("t5_rst_busy",  64'(bus4.busy),    64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    check("t5_no_resume", 64'(bus4.x_valid), 64'd0);
    cap4(VEC_D);
    step();
    bus4.i_valid = '0;
    for (int k = 0; k < 4; k++) begin
      check_word4($sformatf("t5_w%0d", k), 16'(16'hA + k), k == 3);
      step();
    end
    check("t5_busy_fall", 64'(bus4.busy), 64'd0);

    // 6: NN=10, 1000 back-to-back random vectors against a scoreboard
    for (int t = 0; t <= 10000; t++) begin
      if (t > 0) begin
        check("t6_valid", 64'(bus10.x_valid), 64'd1);
        if (sb.size() == 0) begin
          check("t6_sb_empty", 64'd1, 64'd0);
        end else begin
          exp_word = sb.pop_front();
          check("t6_data", 64'(bus10.x_out), 64'(exp_word));
        end
        check("t6_last", 64'(bus10.x_last), 64'(((t - 1) % 10) == 9));
      end
      if ((t % 10 == 0) && (t < 10000)) begin
        for (int j = 0; j < 10; j++) begin
          v10[j*16 +: 16] = 16'($urandom);
          sb.push_back(v10[j*16 +: 16]);
        end
        bus10.i_valid = '1;
        bus10.i_data  = v10;
      end else begin
        bus10.i_valid = '0;
      end
      step();
    end
    check("t6_busy_fall", 64'(bus10.busy),        64'd0);
    check("t6_overrun",   64'(bus10.err_overrun), 64'd0);
    check("t6_partial",   64'(bus10.err_partial), 64'd0);
    check("t6_sb_drain",  64'(sb.size()),         64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
